// File: rtl/can_timing_pkg.sv
// Shared types and constants for the CAN bit timing block.
// Segment encoding, default field widths and the tq counter width.
package can_timing_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        PROP = 2'd1,
        PS1  = 2'd2,
        PS2  = 2'd3
    } seg_e;

    localparam int SEG_W_DEFAULT = 3;
    localparam int SJW_W_DEFAULT = 2;
    localparam int CNT_W         = 4;

    // Phase error e clamped to the synchronisation jump width.
    function automatic logic [CNT_W-1:0] clamp_jump(
        input logic [CNT_W:0] e,
        input logic [CNT_W:0] lim
    );
        logic [CNT_W:0] r;
        r = (e < lim) ? e : lim;
        return CNT_W'(r);
    endfunction

endpackage

// File: rtl/can_bit_timing_if.sv
// Bus between the bit timing block and its surroundings: tq strobe,
// timing configuration, CAN rx level and the resulting timing strobes.
interface can_bit_timing_if
    import can_timing_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEFAULT,
    parameter int SJW_W = SJW_W_DEFAULT
);

    logic             enable;
    logic             tq_pulse;
    logic [SEG_W-1:0] prop_seg;
    logic [SEG_W-1:0] phase_seg1;
    logic [SEG_W-1:0] phase_seg2;
    logic [SJW_W-1:0] sjw;
    logic             hard_sync_en;
    logic             rx;
    logic             bit_start;
    logic             sample_point;
    logic             sampled_bit;
    seg_e             seg;

    modport master (
        output enable, tq_pulse, prop_seg, phase_seg1, phase_seg2, sjw,
               hard_sync_en, rx,
        input  bit_start, sample_point, sampled_bit, seg
    );

    modport slave (
        input  enable, tq_pulse, prop_seg, phase_seg1, phase_seg2, sjw,
               hard_sync_en, rx,
        output bit_start, sample_point, sampled_bit, seg
    );

endinterface

// File: rtl/can_rx_sync_edge.sv
// Two-flop synchroniser for the CAN rx line plus a recessive-to-dominant
// edge detector that only looks at the bus on time-quantum strobes.
module can_rx_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic tq_pulse,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic rx_meta;
    logic rx_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else if (!enable) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (tq_pulse) begin
                rx_prev <= rx_s;
            end
        end
    end

    assign fall_edge = tq_pulse & rx_prev & ~rx_s;

endmodule

// File: rtl/can_bit_timing.sv
// CAN nominal bit timing: walks SYNC/PROP/PS1/PS2 on tq strobes, emits the
// transmit and sample points, and applies hard sync / SJW-limited resync.
module can_bit_timing
    import can_timing_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEFAULT,
    parameter int SJW_W = SJW_W_DEFAULT
)
(
    input  logic            clock,
    input  logic            reset_n,
    can_bit_timing_if.slave bt
);

    localparam int EW = CNT_W + 1;

    logic rx_s;
    logic fall_edge;

    can_rx_sync_edge u_rx_sync_edge (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (bt.enable),
        .tq_pulse  (bt.tq_pulse),
        .rx        (bt.rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    seg_e             seg_q, seg_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] ext_q, ext_n;
    logic [CNT_W-1:0] short_q, short_n;
    logic             resync_done_q, resync_done_n;
    logic             sampled_q, sampled_n;

    logic [SEG_W-1:0] prop_cfg, ph1_cfg, ph2_cfg;
    logic [SJW_W-1:0] sjw_cfg;

    logic             active;
    logic             hard_sync;
    logic             resync;
    logic             force_sync;
    logic             bit_start_c;
    logic             sample_point_c;
    logic [CNT_W-1:0] ext_eff;
    logic [CNT_W-1:0] short_eff;
    logic [EW-1:0]    e_val;
    logic [EW-1:0]    sjw_len;

    assign active    = bt.enable & reset_n & bt.tq_pulse;
    assign hard_sync = active & fall_edge & bt.hard_sync_en;
    assign resync    = active & fall_edge & ~bt.hard_sync_en & ~resync_done_q;
    assign sjw_len   = EW'(sjw_cfg) + EW'(1);

    // Phase error: tq since end of SYNC before the sample point,
    // tq remaining in PS2 (including the current one) after it.
    always_comb begin
        e_val = '0;
        case (seg_q)
            PROP:    e_val = EW'(cnt_q) + EW'(1);
            PS1:     e_val = EW'(prop_cfg) + EW'(cnt_q) + EW'(2);
            PS2:     e_val = EW'(ph2_cfg) + EW'(1) - EW'(cnt_q) - EW'(short_q);
            default: e_val = '0;
        endcase
    end

    always_comb begin
        seg_n          = seg_q;
        cnt_n          = cnt_q;
        ext_n          = ext_q;
        short_n        = short_q;
        resync_done_n  = resync_done_q;
        sampled_n      = sampled_q;
        bit_start_c    = 1'b0;
        sample_point_c = 1'b0;
        force_sync     = 1'b0;
        ext_eff        = ext_q;
        short_eff      = short_q;

        // The resync adjustment is resolved first so that an edge on the
        // last tq of a segment can still move that segment's end.
        if (resync) begin
            resync_done_n = 1'b1;
            case (seg_q)
                PROP, PS1: ext_eff = clamp_jump(e_val, sjw_len);
                PS2: begin
                    if (e_val <= sjw_len) begin
                        force_sync = 1'b1;
                    end else begin
                        short_eff = CNT_W'(sjw_len);
                    end
                end
                default: ;
            endcase
        end

        if (active) begin
            ext_n   = ext_eff;
            short_n = short_eff;
            if (hard_sync || force_sync || seg_q == SYNC) begin
                bit_start_c = 1'b1;
                seg_n       = PROP;
                cnt_n       = '0;
                short_n     = '0;
                if (hard_sync) begin
                    ext_n         = '0;
                    resync_done_n = 1'b0;
                end
            end else begin
                case (seg_q)
                    PROP: begin
                        if (cnt_q >= CNT_W'(prop_cfg)) begin
                            seg_n = PS1;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                    PS1: begin
                        if (cnt_q >= CNT_W'(ph1_cfg) + ext_eff) begin
                            sample_point_c = 1'b1;
                            sampled_n      = rx_s;
                            ext_n          = '0;
                            resync_done_n  = 1'b0;
                            seg_n          = PS2;
                            cnt_n          = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                    PS2: begin
                        if (cnt_q + short_eff >= CNT_W'(ph2_cfg)) begin
                            seg_n = SYNC;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_q         <= SYNC;
            cnt_q         <= '0;
            ext_q         <= '0;
            short_q       <= '0;
            resync_done_q <= 1'b0;
            sampled_q     <= 1'b1;
            prop_cfg      <= '0;
            ph1_cfg       <= '0;
            ph2_cfg       <= '0;
            sjw_cfg       <= '0;
        end else if (!bt.enable) begin
            seg_q         <= SYNC;
            cnt_q         <= '0;
            ext_q         <= '0;
            short_q       <= '0;
            resync_done_q <= 1'b0;
            sampled_q     <= 1'b1;
            prop_cfg      <= bt.prop_seg;
            ph1_cfg       <= bt.phase_seg1;
            ph2_cfg       <= bt.phase_seg2;
            sjw_cfg       <= bt.sjw;
        end else begin
            seg_q         <= seg_n;
            cnt_q         <= cnt_n;
            ext_q         <= ext_n;
            short_q       <= short_n;
            resync_done_q <= resync_done_n;
            sampled_q     <= sampled_n;
            if (bit_start_c) begin
                prop_cfg <= bt.prop_seg;
                ph1_cfg  <= bt.phase_seg1;
                ph2_cfg  <= bt.phase_seg2;
                sjw_cfg  <= bt.sjw;
            end
        end
    end

    assign bt.bit_start    = bit_start_c;
    assign bt.sample_point = sample_point_c;
    assign bt.sampled_bit  = sampled_q;
    assign bt.seg          = seg_q;

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Consumes the single-cycle `tq_pulse` strobes from `tq_generator` and divides each nominal CAN bit into SYNC, PROP, PS1 and PS2 segments.
- Generates `bit_start` (the transmit point) and `sample_point` strobes, and the sampled bus value.
- Performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges of `rx`.
- Sits between `tq_generator` and the bit stream processor / transmitter.

Parameters:
SEG_W, 3, width of segment configuration fields (stored length = field+1 tq, i.e. 1..8)
SJW_W, 2, width of sjw field (stored value = field+1 tq, i.e. 1..4)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  block enable; 0 = idle
tq_pulse  input  1  one-cycle time-quantum strobe from tq_generator
prop_seg  input  SEG_W  propagation segment length-1
phase_seg1  input  SEG_W  phase segment 1 length-1
phase_seg2  input  SEG_W  phase segment 2 length-1
sjw  input  SJW_W  synchronisation jump width-1
hard_sync_en  input  1  1 = bus idle / awaiting SOF; next edge is a hard sync
rx  input  1  asynchronous CAN bus level (1 = recessive)
bit_start  output  1  one-cycle pulse; current tq is SYNC (transmit point)
sample_point  output  1  one-cycle pulse on last tq of PS1
sampled_bit  output  1  rx value captured at sample point, held until the next one
seg  output  2  current segment (seg_e)

Behaviour:
- Reset / enable:
  - Reset values: `bit_start`=0, `sample_point`=0, `sampled_bit`=1, `seg`=SYNC, counter=0, rx synchroniser=1, rx_prev=1, ext=0, resync_done=0.
  - `enable`=0 is the same as reset, held synchronously; `tq_pulse` is ignored.
- rx path:
  - Two-flop synchroniser produces `rx_s`, 2 cycles after `rx`.
  - At every `tq_pulse`: `edge` = rx_prev & ~rx_s, then rx_prev<=rx_s.
  - Edges are evaluated only on `tq_pulse` cycles.
- Processing rule: each `tq_pulse` cycle processes the tq named by `seg`/cnt. Output pulses are asserted in that same cycle; state updates take effect on the next clock.
- Configuration latch: all configuration inputs are latched into internal registers on every `bit_start` cycle and while idle. Mid-bit changes take effect at the next bit.
- Segment sequence:
  - SYNC (1 tq) -> PROP (prop_seg+1) -> PS1 (phase_seg1+1+ext) -> PS2 (phase_seg2+1-shorten) -> SYNC.
  - cnt counts tq within the segment, 4 bits wide (maximum 12).
- Strobes:
  - `bit_start`=1 when processing a SYNC tq.
  - `sample_point`=1 and `sampled_bit`<=rx_s when processing the last PS1 tq.
  - At the sample point, ext<=0 and resync_done<=0.
- Hard sync (`edge` & `hard_sync_en`):
  - The current tq is treated as SYNC regardless of seg: `bit_start`=1, next seg=PROP with cnt=0.
  - ext=0, shorten=0, resync_done=0. Hard sync has priority over resync.
- Resync (`edge` & ~`hard_sync_en` & ~resync_done): sets resync_done=1.
  - Edge in SYNC: no action.
  - Edge in PROP/PS1: e = tq index since end of SYNC (first PROP tq = 1). ext = min(e, sjw+1).
  - Edge in PS2: e = tq remaining in PS2 including the current one.
    - If e <= sjw+1: the current tq becomes SYNC (`bit_start`=1, next PROP).
    - Else PS2 is shortened by sjw+1.
  - Edges after resync_done are ignored until the next sample point.
- Simultaneous events:
  - The edge tq that ends a segment is processed with the resync rule first, then the segment transition.
  - Extending PS1 on its last tq delays `sample_point` by ext.

Decomposition:
- Shared package can_timing_pkg:
  - enum seg_e {SYNC, PROP, PS1, PS2}
  - SEG_W/SJW_W defaults
  - CNT_W=4 constant
- Sub-module can_rx_sync_edge: two-flop synchroniser plus tq-gated edge detector (rx_s, edge).

Test Plan:
- Common setup: prop_seg=1, phase_seg1=2, phase_seg2=2, sjw=1, tq_pulse every 6 clocks, rx=1 (segment lengths 2/3/3, 9 tq per bit).
- Idle run, common setup -> `bit_start` on tq 0, 9, 18; `sample_point` on tq 5, 14; `sampled_bit`=1.
- Hard sync: `hard_sync_en`=1, rx falls during tq 6 -> `bit_start` on that tq; next `sample_point` 5 tq later; `sampled_bit`=0.
- Late edge: rx 1->0 seen at PS1 tq index 3 (e=3) -> ext=2; `sample_point` at tq 7 instead of 5; next `bit_start` at tq 11.
- Early edge: edge at first PS2 tq (e=3 > 2) -> PS2 shortened by 2; `bit_start` at tq 7. Edge at last PS2 tq (e=1) -> that tq pulses `bit_start`.
- Second edge in same bit after resync -> ignored; timing unchanged. A config change mid-bit applies only after the next `bit_start`.
- Reset or `enable`=0 during PS1 -> outputs 0, seg=SYNC, `sampled_bit`=1. After `enable`=1, first `tq_pulse` gives `bit_start`.
